hw_index_sched: RTL

- Controller that drains 80-bit words from the 80-bit sync FIFO and turns each word into a stream of set-bit indices.
- Each word also produces its Hamming weight, delivered on a valid/ready output channel.
- Sits between the FIFO read port and the downstream index/weight consumer.
- Owns the FIFO `rd` strobe and accounts for the FIFO's one-cycle registered read latency.

---
 rtl/hw_index_pkg.sv | 35 +++
 rtl/hw_lsb_encoder.sv | 12 +
 rtl/hw_index_sched.sv | 100 ++++++++++
 3 files changed

// File: rtl/hw_index_pkg.sv
// Shared widths, FSM state encoding and bit-scan helpers for the index scheduler.
package hw_index_pkg;

    localparam int DATA_W = 80;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t SCAN = 2'd2;

    function automatic logic [CNT_W-1:0] popcount_80(input logic [DATA_W-1:0] data);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cnt = cnt + CNT_W'(data[i]);
        end
        return cnt;
    endfunction

    // Returns {found, idx}; idx is 0 when no bit is set.
    function automatic logic [IDX_W:0] lsb_index_80(input logic [DATA_W-1:0] data);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (data[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hw_lsb_encoder.sv
// Combinational lowest-set-bit priority encoder over one data word.
module hw_lsb_encoder
    import hw_index_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    assign {found, idx} = lsb_index_80(data);

endmodule

// File: rtl/hw_index_sched.sv
// Drains words from a sync FIFO and streams each word's set-bit indices plus its weight.
module hw_index_sched
    import hw_index_pkg::*;
#(
    parameter int WCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_emp,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_none,
    output logic              out_last,
    output logic [CNT_W-1:0]  out_weight,
    output logic              busy,
    output logic [WCNT_W-1:0] words_done
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]   weight_q, weight_d;
    logic [WCNT_W-1:0]  done_q;

    logic               found;
    logic [IDX_W-1:0]   lsb_idx;
    logic               single;
    logic               pop_ok;
    logic               last_hs;

    hw_lsb_encoder u_enc (
        .data  (work_q),
        .found (found),
        .idx   (lsb_idx)
    );

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    assign single  = (work_q & (work_q - DATA_W'(1))) == '0;
    assign pop_ok  = en & ~fifo_emp & ~rst;
    assign last_hs = out_valid & out_ready & out_last;

    always_comb begin
        out_valid  = (state_q == SCAN);
        out_idx    = lsb_idx;
        out_none   = ~found;
        out_last   = ~found | single;
        out_weight = weight_q;
        busy       = (state_q != IDLE);
        words_done = done_q;

        fifo_rd  = 1'b0;
        state_d  = state_q;
        work_d   = work_q;
        weight_d = weight_q;

        case (state_q)
            IDLE: begin
                if (pop_ok) begin
                    fifo_rd = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                work_d   = fifo_data;
                weight_d = popcount_80(fifo_data);
                state_d  = SCAN;
            end
            SCAN: begin
                if (out_ready) begin
                    work_d = work_q & ~(DATA_W'(1) << lsb_idx);
                    if (out_last) begin
                        fifo_rd = pop_ok;
                        state_d = pop_ok ? LOAD : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            weight_q <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            weight_q <= weight_d;
            if (last_hs) begin
                done_q <= done_q + WCNT_W'(1);
            end
        end
    end

endmodule
